// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register pending-write scoreboard for hazard stalls.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR*AW-1:0] rn_i,
  input  logic [NR-1:0]    rd_en_i,
  output logic [NR*DW-1:0] a_o,
  output logic [NR-1:0]    rbusy_o,
  output logic             stall_o,
  input  logic             write_i,
  input  logic [AW-1:0]    wn_i,
  input  logic [DW-1:0]    wd_i,
  input  logic             issue_i,
  input  logic [AW-1:0]    issue_wn_i
);

  localparam int unsigned DEPTH = 32'(1) << AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             wr_valid;

  assign wr_valid = write_i && (wn_i != '0);

  // Scoreboard next state: the issue is applied last so it wins over a same-cycle write.
  always_comb begin
    busy_d = busy_q;
    if (write_i) begin
      busy_d[wn_i] = 1'b0;
    end
    if (issue_i) begin
      busy_d[issue_wn_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Register array and busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        regs_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_valid) begin
        regs_q[wn_i] <= wd_i;
      end
      busy_q <= busy_d;
    end
  end

  // Combinational read ports; r0 always reads zero.
  for (genvar g = 0; g < int'(NR); g++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] stored;
    assign addr   = rn_i[g*AW +: AW];
    assign stored = (addr == '0) ? '0 : regs_q[addr];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit                = wr_valid && (addr == wn_i);
    assign a_o[g*DW +: DW]    = hit ? wd_i : stored;
    assign rbusy_o[g]         = hit ? 1'b0 : busy_q[addr];
`else
    assign a_o[g*DW +: DW]    = stored;
    assign rbusy_o[g]         = busy_q[addr];
`endif
  end

  assign stall_o = |(rd_en_i & rbusy_o);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (DW=32, AW=5, NR=2) against an array-based reference model.
// Expectations track REGFILE_BYPASS_EN when the bench is built with that macro.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rn;
  logic [1:0]  rd_en;
  logic [63:0] a;
  logic [1:0]  rbusy;
  logic        stall;
  logic        write;
  logic [4:0]  wn;
  logic [31:0] wd;
  logic        issue;
  logic [4:0]  iwn;

  int checks;
  int failures;

  logic [31:0] mregs [32];
  bit          mbusy [32];

  regfile_sb #(.DW(32), .AW(5), .NR(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rn_i      (rn),
    .rd_en_i   (rd_en),
    .a_o       (a),
    .rbusy_o   (rbusy),
    .stall_o   (stall),
    .write_i   (write),
    .wn_i      (wn),
    .wd_i      (wd),
    .issue_i   (issue),
    .issue_wn_i(iwn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit bypass_on();
`ifdef REGFILE_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_a(int p);
    logic [4:0] ad;
    ad = rn[p*5 +: 5];
    if (!rst_n) return 32'd0;
    if (bypass_on() && write && wn != 5'd0 && ad == wn) return wd;
    if (ad == 5'd0) return 32'd0;
    return mregs[ad];
  endfunction

  function automatic logic exp_rbusy(int p);
    logic [4:0] ad;
    ad = rn[p*5 +: 5];
    if (!rst_n) return 1'b0;
    if (bypass_on() && write && wn != 5'd0 && ad == wn) return 1'b0;
    return mbusy[ad];
  endfunction

  function automatic logic exp_stall();
    return (rd_en[0] && exp_rbusy(0)) || (rd_en[1] && exp_rbusy(1));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin
      mregs[k] = 32'd0;
      mbusy[k] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    write = 1'b0; wn = 5'd0; wd = 32'd0;
    issue = 1'b0; iwn = 5'd0; rd_en = 2'b00;
  endtask

  // One rising edge; the model applies the scoreboard rules to the inputs held at that edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 1; k < 32; k++) begin
      if (issue && iwn == 5'(k)) mbusy[k] = 1'b1;
      else if (write && wn == 5'(k)) mbusy[k] = 1'b0;
    end
    if (write && wn != 5'd0) mregs[wn] = wd;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    rn = {5'd9, 5'd3};
    rd_en = 2'b11;
    model_clear();
    #3;
    checks++;
    if (a !== 64'd0) begin
      failures++; $display("FAIL reset_a got=%h want=0", a);
    end
    checks++;
    if (rbusy !== 2'b00 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_busy got rbusy=%b stall=%b want 00/0", rbusy, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_write_read();
    write = 1'b1; wn = 5'd1; wd = 32'd1023;
    tick();
    idle_inputs();
    rn = {5'd3, 5'd1};
    #1;
    checks++;
    if (a[31:0] !== 32'd1023 || a[63:32] !== 32'd0) begin
      failures++; $display("FAIL write_r1 got p0=%0d p1=%0d want 1023/0", a[31:0], a[63:32]);
    end
    write = 1'b1; wn = 5'd3; wd = 32'd2047;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (a[31:0] !== 32'd1023 || a[63:32] !== 32'd2047) begin
      failures++; $display("FAIL write_r3 got p0=%0d p1=%0d want 1023/2047", a[31:0], a[63:32]);
    end
    write = 1'b1; wn = 5'd0; wd = 32'd5;
    tick();
    idle_inputs();
    rn = {5'd0, 5'd0};
    #1;
    checks++;
    if (a !== 64'd0) begin
      failures++; $display("FAIL r0_zero got=%h want=0", a);
    end
  endtask

  task automatic test_scoreboard();
    issue = 1'b1; iwn = 5'd4;
    tick();
    idle_inputs();
    rn = {5'd1, 5'd4};
    rd_en = 2'b01;
    #1;
    checks++;
    if (rbusy !== 2'b01 || stall !== 1'b1) begin
      failures++; $display("FAIL busy_r4 got rbusy=%b stall=%b want 01/1", rbusy, stall);
    end
    rd_en = 2'b10;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL stall_unqualified got=%b want=0", stall);
    end
    rd_en = 2'b01;
    write = 1'b1; wn = 5'd4; wd = 32'd77;
    tick();
    write = 1'b0;
    #1;
    checks++;
    if (rbusy !== 2'b00 || stall !== 1'b0 || a[31:0] !== 32'd77) begin
      failures++;
      $display("FAIL clear_r4 got rbusy=%b stall=%b a0=%0d want 00/0/77", rbusy, stall, a[31:0]);
    end
    idle_inputs();
  endtask

  task automatic test_issue_write_same();
    issue = 1'b1; iwn = 5'd5;
    write = 1'b1; wn = 5'd5; wd = 32'd9;
    tick();
    idle_inputs();
    rn = {5'd0, 5'd5};
    rd_en = 2'b01;
    #1;
    checks++;
    if (a[31:0] !== 32'd9 || rbusy[0] !== 1'b1 || stall !== 1'b1) begin
      failures++;
      $display("FAIL issue_wins got a0=%0d busy=%b stall=%b want 9/1/1", a[31:0], rbusy[0], stall);
    end
    write = 1'b1; wn = 5'd5; wd = 32'd10;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rbusy[0] !== 1'b0 || a[31:0] !== 32'd10) begin
      failures++; $display("FAIL issue_wins_clear got busy=%b a0=%0d want 0/10", rbusy[0], a[31:0]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want_a;
    logic        want_b;
    issue = 1'b1; iwn = 5'd6;
    tick();
    idle_inputs();
    rn = {5'd6, 5'd1};
    write = 1'b1; wn = 5'd6; wd = 32'hABCD;
    #1;
    want_a = bypass_on() ? 32'hABCD : 32'd0;
    want_b = bypass_on() ? 1'b0 : 1'b1;
    checks++;
    if (a[63:32] !== want_a || rbusy[1] !== want_b) begin
      failures++;
      $display("FAIL bypass got a1=%h busy1=%b want %h/%b", a[63:32], rbusy[1], want_a, want_b);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (a[63:32] !== 32'hABCD || rbusy[1] !== 1'b0) begin
      failures++; $display("FAIL bypass_after got a1=%h busy1=%b want abcd/0", a[63:32], rbusy[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rn    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_en = 2'($urandom);
      write = 1'($urandom);
      wn    = 5'($urandom_range(0, 7));
      wd    = $urandom;
      issue = ($urandom_range(0, 2) == 0);
      iwn   = (c % 16 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (a[p*32 +: 32] !== exp_a(p) || rbusy[p] !== exp_rbusy(p)) begin
          failures++;
          $display("FAIL rand_port%0d cyc=%0d got a=%h busy=%b want a=%h busy=%b",
                   p, c, a[p*32 +: 32], rbusy[p], exp_a(p), exp_rbusy(p));
        end
      end
      checks++;
      if (stall !== exp_stall()) begin
        failures++; $display("FAIL rand_stall cyc=%0d got=%b want=%b", c, stall, exp_stall());
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midway();
    issue = 1'b1; iwn = 5'd7;
    write = 1'b1; wn = 5'd1; wd = 32'd55;
    tick();
    idle_inputs();
    rn = {5'd7, 5'd1};
    rd_en = 2'b10;
    #1;
    checks++;
    if (rbusy[1] !== 1'b1 || stall !== 1'b1 || a[31:0] !== 32'd55) begin
      failures++;
      $display("FAIL pre_reset got busy1=%b stall=%b a0=%0d want 1/1/55", rbusy[1], stall, a[31:0]);
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (a !== 64'd0 || rbusy !== 2'b00 || stall !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got a=%h rbusy=%b stall=%b want 0/00/0", a, rbusy, stall);
    end
    #1;
    rst_n = 1'b1;
    tick();
    #1;
    checks++;
    if (a[31:0] !== 32'd0 || rbusy !== 2'b00 || stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got a0=%0d rbusy=%b stall=%b want 0/00/0", a[31:0], rbusy, stall);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    rn = '0;
    rst_n = 1'b0;
    model_clear();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_issue_write_same();
    test_bypass();
    test_random();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
